lemming_world: RTL and testbench
================================

# lemming_world

Level/physics model that sits in the loop beside the lemming walker FSM. It consumes that FSM's state outputs (`walk_left`, `walk_right`, `aaah`, `digging`) and produces the environment inputs it needs (`ground`, `bump_left`, `bump_right`). It tracks the lemming's column and altitude over a 1-D terrain of stacked ground layers, and it models walking, falling, digging and bottomless pits cycle by cycle.

## Interface
- `WIDTH`, 16: number of terrain columns; XW = $clog2(WIDTH).
- `DEPTH`, 7: maximum column height in layers; HW = $clog2(DEPTH+1).
- `INIT_MAP`, {16{3'd3}}: flat WIDTH*HW vector of column heights loaded at reset. Column c is at bits [c*HW +: HW]. 0 = bottomless pit.
- `START_X`, 8: lemming column after reset.
- `WALK_DIV`, 2: cycles of continuous walking per one-column move (≥1).
- `DIG_CYCLES`, 4: cycles of continuous digging per removed layer (≥1).

Ports:
- `clk`  in  1  clock.
- `areset`  in  1  reset. Synchronous and active-high.
- `walk_left`, `walk_right`, `aaah`, `digging`  in  1 each  walker FSM state outputs.
- `map_we`  in  1  terrain write strobe.
- `map_addr`  in  XW  column to write.
- `map_data`  in  HW  new height; values >DEPTH are clamped to DEPTH.
- `ground`  out  1  lemming is standing on solid ground.
- `bump_left`, `bump_right`  out  1 each  wall directly to the left/right.
- `pos_x`  out  XW  current column.
- `alt`  out  HW  current altitude, in layers above the world floor.
- `lost`  out  1  lemming is at the bottom of a pit.

## Operation
- State: height array h[0..WIDTH-1], x, a, step counter (0..WALK_DIV-1), dig counter (0..DIG_CYCLES-1).
- Reset (sync): h ← INIT_MAP, x ← START_X, a ← INIT_MAP height at START_X, both counters ← 0. Any map write in the reset cycle is dropped.
- Combinational outputs, derived from registered state only:
  - ground = (h[x] ≠ 0) && (a == h[x]).
  - bump_left = (x == 0) || (h[x−1] > a).
  - bump_right = (x == WIDTH−1) || (h[x+1] > a).
  - lost = (h[x] == 0) && (a == 0).
  - pos_x = x, alt = a.
- Per clock edge, action priority aaah > digging > walk. Exactly one action is evaluated per cycle.
- Fall: if aaah && !ground, then a ← a−1 when a > 0. When a reaches h[x], no further decrement. In a pit, a saturates at 0.
- Dig: if digging && ground, the dig counter increments. At DIG_CYCLES−1, h[x] ← h[x]−1 and the counter ← 0; a is unchanged, so ground drops the next cycle. Digging the last layer leaves h[x] = 0, which makes the column a pit.
- Walk: the lemming walks if exactly one of walk_left/walk_right is set, ground is 1, and the bump in that direction is 0. The step counter increments; at WALK_DIV−1, x moves ±1 and the counter ← 0. a is unchanged, so stepping onto a lower column produces ground = 0 (a step-down fall).
- Counter clearing: the step counter clears on any cycle with no valid walk. The dig counter clears on any cycle with no valid dig.
- Illegal combinations: walk_left && walk_right, or any action with ground = 0 other than a fall → no change.
- Map write (map_we, not in reset): h[map_addr] ← clamp(map_data).
  - Writes to map_addr == x are dropped.
  - Writes with map_addr ≥ WIDTH are dropped.
  - A write that coincides with a dig on another column: both take effect.

## Timing
- All state updates at posedge clk. Outputs change combinationally from the new state in the same cycle as the update, so the FSM sees them at its next edge.
- Move latency: WALK_DIV cycles of continuous walk per column.
- Fall rate: 1 layer/cycle while aaah.
- Dig latency: DIG_CYCLES cycles per layer. ground is 0 in the cycle immediately after the layer is removed.
- Loop timing: the FSM enters FALL one edge after ground drops, so a begins decrementing one cycle after that.
- Reset mid-operation: takes precedence over every action and write. The map is restored to INIT_MAP, and the next-cycle outputs equal the post-reset values.

## Test plan
- Reset with default map → pos_x = 8, alt = 3, ground = 1, bump_left = bump_right = 0, lost = 0.
- walk_left held from x = 8 → pos_x decrements every 2 cycles, reaching 0 after 16 cycles. Then bump_left = 1 and pos_x holds at 0.
- Write h[7] = 1, then walk_left from x = 8 → after the move, pos_x = 7 and ground = 0. With aaah held, alt goes 3→2→1 over 2 cycles, then ground = 1 and alt holds.
- Write h[9] = 5 → bump_right = 1 at x = 8. walk_right held for 10 cycles → pos_x stays 8. A write to column 8 is ignored (h[8] stays 3).
- digging held at x = 8 → h[8] 3→2 after 4 cycles and ground = 0 for one cycle. With aaah asserted, alt → 2 and ground = 1. Drop digging after 2 cycles → dig counter clears, no layer removed.
- Dig column 8 down to 0 → ground stays 0. With aaah held, alt reaches 0, then lost = 1. Assert areset mid-fall → next cycle alt = 3, h[8] = 3, lost = 0.

Source files
------------

// File: rtl/lemming_world.sv
// Terrain/physics companion to the lemming walker FSM: tracks column, altitude
// and a per-column height map, and feeds ground/bump back to the walker.
module lemming_world #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 7,
    localparam int XW        = $clog2(WIDTH),
    localparam int HW        = $clog2(DEPTH + 1),
    parameter logic [WIDTH*HW-1:0] INIT_MAP = {16{3'd3}},
    parameter int START_X    = 8,
    parameter int WALK_DIV   = 2,
    parameter int DIG_CYCLES = 4
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    input  logic          map_we,
    input  logic [XW-1:0] map_addr,
    input  logic [HW-1:0] map_data,
    output logic          ground,
    output logic          bump_left,
    output logic          bump_right,
    output logic [XW-1:0] pos_x,
    output logic [HW-1:0] alt,
    output logic          lost
);

    localparam int SW = $clog2(WALK_DIV + 1);
    localparam int DW = $clog2(DIG_CYCLES + 1);

    logic [HW-1:0] h [WIDTH];
    logic [XW-1:0] x;
    logic [HW-1:0] a;
    logic [SW-1:0] step;
    logic [DW-1:0] dig;

    logic [HW-1:0] h_here;
    logic [HW-1:0] h_left;
    logic [HW-1:0] h_right;
    logic          walk_ok;
    logic [XW-1:0] x_n;
    logic [HW-1:0] a_n;
    logic [SW-1:0] step_n;
    logic [DW-1:0] dig_n;
    logic          dig_take;
    logic          wr_ok;
    logic [HW-1:0] wr_val;

    // Neighbour heights; off-map neighbours read as 0 and the edge bump covers them.
    always_comb begin
        h_here = h[x];
        if (x == XW'(0)) begin
            h_left = HW'(0);
        end else begin
            h_left = h[x - XW'(1)];
        end
        if (x == XW'(WIDTH - 1)) begin
            h_right = HW'(0);
        end else begin
            h_right = h[x + XW'(1)];
        end
    end

    assign ground     = (h_here != HW'(0)) && (a == h_here);
    assign bump_left  = (x == XW'(0)) || (h_left > a);
    assign bump_right = (x == XW'(WIDTH - 1)) || (h_right > a);
    assign lost       = (h_here == HW'(0)) && (a == HW'(0));
    assign pos_x      = x;
    assign alt        = a;

    assign walk_ok = (walk_left ^ walk_right) && ground &&
                     !(walk_left ? bump_left : bump_right);
    assign wr_ok   = map_we && (map_addr != x) &&
                     ({1'b0, map_addr} < (XW + 1)'(WIDTH));
    assign wr_val  = ({1'b0, map_data} > (HW + 1)'(DEPTH)) ? HW'(DEPTH) : map_data;

    // One action per cycle, aaah over digging over walking; counters clear when idle.
    always_comb begin
        x_n      = x;
        a_n      = a;
        step_n   = SW'(0);
        dig_n    = DW'(0);
        dig_take = 1'b0;
        if (aaah) begin
            if (!ground && (a > h_here)) begin
                a_n = a - HW'(1);
            end else begin
                a_n = a;
            end
        end else if (digging) begin
            if (ground && (dig == DW'(DIG_CYCLES - 1))) begin
                dig_take = 1'b1;
            end else if (ground) begin
                dig_n = dig + DW'(1);
            end else begin
                dig_n = DW'(0);
            end
        end else if (walk_ok) begin
            if (step == SW'(WALK_DIV - 1)) begin
                x_n = walk_left ? (x - XW'(1)) : (x + XW'(1));
            end else begin
                step_n = step + SW'(1);
            end
        end else begin
            step_n = SW'(0);
        end
    end

    // State and height map; writes to the lemming's own column never happen,
    // so a write and a dig can never target the same entry.
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < WIDTH; i++) begin
                h[i] <= INIT_MAP[i*HW +: HW];
            end
            x    <= XW'(START_X);
            a    <= INIT_MAP[START_X*HW +: HW];
            step <= SW'(0);
            dig  <= DW'(0);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_ok && (map_addr == XW'(i))) begin
                    h[i] <= wr_val;
                end else if (dig_take && (x == XW'(i))) begin
                    h[i] <= h[i] - HW'(1);
                end else begin
                    h[i] <= h[i];
                end
            end
            x    <= x_n;
            a    <= a_n;
            step <= step_n;
            dig  <= dig_n;
        end
    end

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: vector table, directed corner sequences, and a
// randomized run against an integer reference model of the world rules.
module tb_lemming_world;

    logic       clk = 1'b0;
    logic       areset, walk_left, walk_right, aaah, digging, map_we;
    logic [3:0] map_addr;
    logic [2:0] map_data;
    logic       ground, bump_left, bump_right, lost;
    logic [3:0] pos_x;
    logic [2:0] alt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lemming_world dut (
        .clk(clk), .areset(areset),
        .walk_left(walk_left), .walk_right(walk_right),
        .aaah(aaah), .digging(digging),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .ground(ground), .bump_left(bump_left), .bump_right(bump_right),
        .pos_x(pos_x), .alt(alt), .lost(lost)
    );

    typedef struct {
        logic wl, wr, aa, dg;
        int   ex, ea, eg, ebl, ebr, elost;
    } vec_t;
    vec_t vecs[21];

    // reference model state
    int mh[16];
    int mx, ma, ms, md;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        areset = 1'b0; walk_left = 1'b0; walk_right = 1'b0;
        aaah = 1'b0; digging = 1'b0; map_we = 1'b0;
        map_addr = 4'd0; map_data = 3'd0;
    endtask

    task automatic do_reset();
        idle_in();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    function automatic int pack(input int x, a, g, bl, br, l);
        return (x << 9) | (a << 6) | (g << 3) | (bl << 2) | (br << 1) | l;
    endfunction

    function automatic int dut_vec();
        return pack(int'(pos_x), int'(alt), int'(ground), int'(bump_left),
                    int'(bump_right), int'(lost));
    endfunction

    function automatic int m_g();
        return int'(mh[mx] != 0 && ma == mh[mx]);
    endfunction
    function automatic int m_bl();
        if (mx == 0) return 1;
        return int'(mh[mx-1] > ma);
    endfunction
    function automatic int m_br();
        if (mx == 15) return 1;
        return int'(mh[mx+1] > ma);
    endfunction
    function automatic int m_vec();
        return pack(mx, ma, m_g(), m_bl(), m_br(), int'(mh[mx] == 0 && ma == 0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mh[i] = 3;
        mx = 8; ma = 3; ms = 0; md = 0;
    endtask

    task automatic model_step(input logic rst, wl, wr, aa, dg, we,
                              input int addr, input int data);
        int g, bl, br;
        if (rst) begin
            model_reset();
            return;
        end
        g = m_g(); bl = m_bl(); br = m_br();
        if (we && addr != mx && addr < 16) mh[addr] = (data > 7) ? 7 : data;
        if (aa) begin
            ms = 0; md = 0;
            if (g == 0 && ma > mh[mx]) ma = ma - 1;
        end else if (dg) begin
            ms = 0;
            if (g != 0) begin
                md = md + 1;
                if (md == 4) begin
                    mh[mx] = mh[mx] - 1;
                    md = 0;
                end
            end else begin
                md = 0;
            end
        end else begin
            md = 0;
            if ((wl != wr) && g != 0 && ((wl && bl == 0) || (wr && br == 0))) begin
                ms = ms + 1;
                if (ms == 2) begin
                    mx = wl ? mx - 1 : mx + 1;
                    ms = 0;
                end
            end else begin
                ms = 0;
            end
        end
    endtask

    int hold;
    logic r_wl, r_wr, r_aa, r_dg;

    initial begin
        idle_in();

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 3, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 3, 1, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 3, 1, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 3, 1, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 3, 1, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 1, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 3, 1, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 1, 0, 0, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 1, 0, 0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 1, 0, 0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 0, 0, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 2, 1, 1, 1, 0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 2, 1, 1, 1, 0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 2, 1, 1, 1, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 2, 1, 1, 1, 0};

        do_reset();
        chk("reset_state", dut_vec(), pack(8, 3, 1, 0, 0, 0));
        for (int i = 0; i < 21; i++) begin
            walk_left = vecs[i].wl; walk_right = vecs[i].wr;
            aaah = vecs[i].aa; digging = vecs[i].dg;
            tick();
            chk($sformatf("vec%0d", i), dut_vec(),
                pack(vecs[i].ex, vecs[i].ea, vecs[i].eg, vecs[i].ebl, vecs[i].ebr, vecs[i].elost));
        end
        idle_in();

        // ---------------- walk to the left edge ----------------
        do_reset();
        walk_left = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("walkl_c%0d", i), int'(pos_x), 8 - i / 2);
        end
        chk("edge_bump_left", int'(bump_left), 1);
        tick(); tick();
        chk("edge_hold_x", int'(pos_x), 0);
        idle_in();

        // ---------------- step down then fall ----------------
        do_reset();
        map_we = 1'b1; map_addr = 4'd7; map_data = 3'd1;
        tick();
        map_we = 1'b0;
        walk_left = 1'b1;
        tick(); tick();
        walk_left = 1'b0;
        chk("stepdown_x", int'(pos_x), 7);
        chk("stepdown_ground", int'(ground), 0);
        aaah = 1'b1;
        tick();
        chk("fall1", pack(int'(alt), int'(ground), 0, 0, 0, 0), pack(2, 0, 0, 0, 0, 0));
        tick();
        chk("fall2", pack(int'(alt), int'(ground), 0, 0, 0, 0), pack(1, 1, 0, 0, 0, 0));
        tick();
        chk("fall_land_hold", int'(alt), 1);
        idle_in();

        // ---------------- wall, own-column write, reset-cycle write ----------------
        do_reset();
        map_we = 1'b1; map_addr = 4'd9; map_data = 3'd5;
        tick();
        map_we = 1'b0;
        chk("wall_bump_right", int'(bump_right), 1);
        walk_right = 1'b1;
        repeat (10) tick();
        walk_right = 1'b0;
        chk("wall_hold_x", int'(pos_x), 8);
        map_we = 1'b1; map_addr = 4'd8; map_data = 3'd1;
        tick();
        map_we = 1'b0;
        chk("own_col_write_dropped", int'(ground), 1);
        areset = 1'b1; map_we = 1'b1; map_addr = 4'd7; map_data = 3'd7;
        tick();
        idle_in();
        chk("reset_write_dropped", pack(0, 0, 0, int'(bump_left), int'(bump_right), 0), 0);

        // ---------------- dig one layer, interrupted dig ----------------
        do_reset();
        digging = 1'b1;
        tick(); tick(); tick();
        chk("dig_pre", int'(ground), 1);
        tick();
        chk("dig_layer", pack(int'(alt), int'(ground), 0, 0, 0, 0), pack(3, 0, 0, 0, 0, 0));
        digging = 1'b0; aaah = 1'b1;
        tick();
        chk("dig_fall", pack(int'(alt), int'(ground), 0, 0, 0, 0), pack(2, 1, 0, 0, 0, 0));
        aaah = 1'b0; digging = 1'b1;
        tick(); tick();
        digging = 1'b0;
        tick();
        digging = 1'b1;
        tick(); tick();
        digging = 1'b0;
        chk("dig_interrupted", pack(int'(alt), int'(ground), 0, 0, 0, 0), pack(2, 1, 0, 0, 0, 0));

        // ---------------- dig to a pit, fall, reset mid-fall ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            digging = 1'b1;
            repeat (4) tick();
            digging = 1'b0;
            if (k < 2) begin
                aaah = 1'b1;
                tick();
                aaah = 1'b0;
            end
        end
        chk("pit_dug", pack(int'(alt), int'(ground), int'(lost), 0, 0, 0), pack(1, 0, 0, 0, 0, 0));
        aaah = 1'b1;
        tick();
        chk("pit_lost", pack(int'(alt), int'(ground), int'(lost), 0, 0, 0), pack(0, 0, 1, 0, 0, 0));
        tick();
        chk("pit_saturate", pack(int'(alt), int'(lost), 0, 0, 0, 0), pack(0, 1, 0, 0, 0, 0));
        areset = 1'b1;
        tick();
        idle_in();
        chk("reset_midfall", dut_vec(), pack(8, 3, 1, 0, 0, 0));

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        hold = 0;
        r_wl = 1'b0; r_wr = 1'b0; r_aa = 1'b0; r_dg = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                r_wl = ($urandom_range(0, 2) == 0);
                r_wr = ($urandom_range(0, 2) == 0);
                r_aa = ($urandom_range(0, 3) == 0);
                r_dg = ($urandom_range(0, 3) == 0);
                hold = $urandom_range(1, 6);
            end
            hold--;
            areset = ($urandom_range(0, 149) == 0);
            walk_left = r_wl; walk_right = r_wr; aaah = r_aa; digging = r_dg;
            map_we   = ($urandom_range(0, 7) == 0);
            map_addr = 4'($urandom_range(0, 15));
            map_data = 3'($urandom_range(0, 7));
            model_step(areset, walk_left, walk_right, aaah, digging, map_we,
                       int'(map_addr), int'(map_data));
            tick();
            chk($sformatf("rand_c%0d", c), dut_vec(), m_vec());
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
